// File: rtl/soc_system_cpu_debug_ocimem.sv
// ---------------------------------------------------------------------------
// soc_system_cpu_debug_ocimem
//
// Debug on-chip memory controller for the Nios II debug module. Executes
// JTAG-initiated reads/writes (decoded from the system-clock debug stage
// strobes) on a 2^ADDR_W x 32 debug RAM and returns read data on MonDReg.
// The same RAM is shared with a CPU-side Avalon-MM slave; a queued JTAG
// access always owns the RAM in the cycle after its strobe.
//
// Optional feature macro: OCIMEM_CPU_WRITE_PROT_EN
//   defined   -> CPU writes at avs_address >= PROT_BASE complete but are
//                dropped; JTAG writes are unaffected.
//   undefined -> the whole RAM is CPU-writable.
//
// Ports
//   clk, reset                 system clock, synchronous active-high reset
//   jdo[37:0]                  JTAG data word ([35] read flag, [24:17] load
//                              address, [34:3] write data)
//   take_action_ocimem_a       load MonAReg (read there if jdo[35])
//   take_no_action_ocimem_a    read at MonAReg, then increment
//   take_action_ocimem_b       write jdo[34:3] at MonAReg, then increment
//   MonDReg, MonAReg           monitor data / current JTAG word address
//   jtag_busy                  JTAG access pending or executing
//   avs_*                      CPU Avalon-MM slave (read latency via waitrequest)
// ---------------------------------------------------------------------------
module soc_system_cpu_debug_ocimem #(
  parameter int unsigned       ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] PROT_BASE = 8'hC0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  output logic [31:0]       MonDReg,
  output logic [ADDR_W-1:0] MonAReg,
  output logic              jtag_busy,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  input  logic [3:0]        avs_byteenable,
  output logic [31:0]       avs_readdata,
  output logic              avs_waitrequest
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

`ifdef OCIMEM_CPU_WRITE_PROT_EN
  localparam bit PROT_EN = 1'b1;
`else
  localparam bit PROT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_J_RD, S_C_RD} state_t;

  state_t            r_state, w_state_nx;
  logic [ADDR_W-1:0] r_mon_a;
  logic [31:0]       r_mon_d;
  logic [31:0]       r_avs_rdata;
  logic [31:0]       r_ram_q;
  logic              r_jq_valid;
  logic              r_jq_write;
  logic [ADDR_W-1:0] r_jq_addr;
  logic [31:0]       r_jq_data;
  logic [31:0]       r_mem [DEPTH];

  logic              w_take_a, w_take_na, w_take_b;
  logic              w_jq_set, w_jq_rd;
  logic              w_cpu_wr_go, w_cpu_rd_go, w_cpu_wr_allow, w_cpu_done;
  logic [ADDR_W-1:0] w_ld_addr, w_ram_addr;
  logic [31:0]       w_ram_wdata;
  logic [3:0]        w_ram_be;
  logic              w_unused_jdo;

  // Strobe priority: b > a > no_action_a; lower-priority strobes are dropped.
  assign w_take_b  = take_action_ocimem_b;
  assign w_take_a  = take_action_ocimem_a & ~take_action_ocimem_b;
  assign w_take_na = take_no_action_ocimem_a & ~take_action_ocimem_a & ~take_action_ocimem_b;
  assign w_jq_set  = w_take_b | (w_take_a & jdo[35]) | w_take_na;
  assign w_ld_addr = jdo[17 +: ADDR_W];
  assign w_unused_jdo = ^{jdo[37:36], jdo[2:0]};

  // JTAG command capture. Only the valid flag needs reset; the payload is
  // qualified by it.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_jq_valid <= 1'b0;
      r_mon_a    <= '0;
    end else begin
      r_jq_valid <= w_jq_set;
      if (w_take_b) begin
        r_jq_write <= 1'b1;
        r_jq_addr  <= r_mon_a;
        r_jq_data  <= jdo[34:3];
        r_mon_a    <= r_mon_a + ADDR_W'(1);
      end else if (w_take_a) begin
        r_jq_write <= 1'b0;
        r_jq_addr  <= w_ld_addr;
        r_mon_a    <= w_ld_addr;
      end else if (w_take_na) begin
        r_jq_write <= 1'b0;
        r_jq_addr  <= r_mon_a;
        r_mon_a    <= r_mon_a + ADDR_W'(1);
      end
    end
  end

  assign w_jq_rd        = r_jq_valid & ~r_jq_write;
  assign w_cpu_wr_allow = ~(PROT_EN & (avs_address >= PROT_BASE));
  // The CPU may only use the RAM from IDLE when no JTAG access owns it.
  assign w_cpu_wr_go    = (r_state == S_IDLE) & ~r_jq_valid & avs_write;
  assign w_cpu_rd_go    = (r_state == S_IDLE) & ~r_jq_valid & avs_read & ~avs_write;

  // RAM port arbitration.
  // NOTE: every always_comb output gets a default first so no path leaves
  // it unassigned (which would infer a latch).
  always_comb begin
    w_ram_addr  = avs_address;
    w_ram_wdata = avs_writedata;
    w_ram_be    = '0;
    if (r_jq_valid) begin
      w_ram_addr  = r_jq_addr;
      w_ram_wdata = r_jq_data;
      if (r_jq_write) w_ram_be = 4'hF;
    end else if (w_cpu_wr_go && w_cpu_wr_allow) begin
      w_ram_be = avs_byteenable;
    end
    // A queued access is discarded by reset, so it must not reach the RAM.
    if (reset) w_ram_be = '0;
  end

  // NOTE: the RAM array has no reset; contents survive reset and a reset
  // loop would prevent block-RAM inference.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (w_ram_be[b]) r_mem[w_ram_addr][8*b +: 8] <= w_ram_wdata[8*b +: 8];
    end
    r_ram_q <= r_mem[w_ram_addr];
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nx;
  end

  // FSM next state. A CPU read finishing in C_RD does not need the RAM port,
  // so a JTAG read queued in that cycle proceeds straight to J_RD.
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_jq_rd)          w_state_nx = S_J_RD;
        else if (w_cpu_rd_go) w_state_nx = S_C_RD;
      end
      S_J_RD:  w_state_nx = S_IDLE;
      S_C_RD:  w_state_nx = w_jq_rd ? S_J_RD : S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Data capture registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mon_d     <= '0;
      r_avs_rdata <= '0;
    end else begin
      if (w_take_b)                r_mon_d <= jdo[34:3];
      else if (r_state == S_J_RD)  r_mon_d <= r_ram_q;
      if (r_state == S_C_RD)       r_avs_rdata <= r_ram_q;
    end
  end

  assign w_cpu_done      = w_cpu_wr_go | ((r_state == S_C_RD) & avs_read);
  assign avs_waitrequest = (avs_read | avs_write) & (reset | ~w_cpu_done);
  // RAM output is forwarded in C_RD so data is valid while waitrequest is low.
  assign avs_readdata    = (r_state == S_C_RD) ? r_ram_q : r_avs_rdata;
  assign MonDReg         = r_mon_d;
  assign MonAReg         = r_mon_a;
  assign jtag_busy       = r_jq_valid | (r_state == S_J_RD);

endmodule

// File: tb/tb_soc_system_cpu_debug_ocimem.sv
// ---------------------------------------------------------------------------
// tb_soc_system_cpu_debug_ocimem
//
// Directed testbench for soc_system_cpu_debug_ocimem. A vector table covers
// CPU/JTAG reads and writes, address wrap, byte enables, strobe priority and
// write protection; hand-written sequences cover JTAG read timing, CPU/JTAG
// contention and reset in the middle of a JTAG read.
// ---------------------------------------------------------------------------
module tb_soc_system_cpu_debug_ocimem;

  typedef enum {OP_CW, OP_CR, OP_JL, OP_JLR, OP_JW, OP_JN, OP_JBA} op_e;

  typedef struct {
    op_e         op;
    logic [7:0]  addr;   // CPU address, or expected MonAReg after a JTAG strobe
    logic [31:0] data;
    logic [3:0]  be;
    logic [31:0] exp;
  } vec_t;

`ifdef OCIMEM_CPU_WRITE_PROT_EN
  localparam logic [31:0] PROT_EXP = 32'h1234_5678;
`else
  localparam logic [31:0] PROT_EXP = 32'h0000_0055;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [37:0] jdo;
  logic        take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b;
  logic [31:0] MonDReg;
  logic [7:0]  MonAReg;
  logic        jtag_busy;
  logic [7:0]  avs_address;
  logic        avs_read, avs_write;
  logic [31:0] avs_writedata;
  logic [3:0]  avs_byteenable;
  logic [31:0] avs_readdata;
  logic        avs_waitrequest;

  int n_cmp  = 0;
  int n_fail = 0;

  soc_system_cpu_debug_ocimem dut (
    .clk                     (clk),
    .reset                   (reset),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .MonDReg                 (MonDReg),
    .MonAReg                 (MonAReg),
    .jtag_busy               (jtag_busy),
    .avs_address             (avs_address),
    .avs_read                (avs_read),
    .avs_write               (avs_write),
    .avs_writedata           (avs_writedata),
    .avs_byteenable          (avs_byteenable),
    .avs_readdata            (avs_readdata),
    .avs_waitrequest         (avs_waitrequest)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required $finish)");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // All tasks start and end 1 time unit after a rising edge.
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [37:0] mk_jdo_a(input logic rd, input logic [7:0] a);
    logic [37:0] j;
    j = '0;
    j[35] = rd;
    j[24:17] = a;
    return j;
  endfunction

  function automatic logic [37:0] mk_jdo_b(input logic [31:0] d);
    logic [37:0] j;
    j = '0;
    j[34:3] = d;
    return j;
  endfunction

  // One-cycle strobe; returns in cycle T+1.
  task automatic pulse(input logic sa, input logic sna, input logic sb, input logic [37:0] j);
    jdo = j;
    take_action_ocimem_a    = sa;
    take_no_action_ocimem_a = sna;
    take_action_ocimem_b    = sb;
    @(posedge clk); #1;
    jdo = '0;
    take_action_ocimem_a    = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    take_action_ocimem_b    = 1'b0;
  endtask

  task automatic jtag_op(input logic sa, input logic sna, input logic sb, input logic [37:0] j,
                         output logic [7:0] a1, output logic bz1,
                         output logic [31:0] d1, output logic [31:0] dend);
    pulse(sa, sna, sb, j);
    @(negedge clk);
    a1  = MonAReg;
    bz1 = jtag_busy;
    d1  = MonDReg;
    repeat (8) @(posedge clk);
    @(negedge clk);
    dend = MonDReg;
    @(posedge clk); #1;
  endtask

  task automatic cpu_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be,
                           output int waits);
    bit done;
    done = 1'b0;
    waits = 0;
    avs_address = a; avs_writedata = d; avs_byteenable = be; avs_write = 1'b1;
    while (!done && waits < 20) begin
      @(negedge clk);
      if (!avs_waitrequest) done = 1'b1;
      else waits++;
      @(posedge clk); #1;
    end
    avs_write = 1'b0;
    if (!done) waits = 99;
  endtask

  task automatic cpu_read(input logic [7:0] a, output logic [31:0] d, output int waits);
    bit done;
    done = 1'b0;
    waits = 0;
    d = 'x;
    avs_address = a; avs_read = 1'b1;
    while (!done && waits < 20) begin
      @(negedge clk);
      if (!avs_waitrequest) begin
        done = 1'b1;
        d = avs_readdata;
      end else waits++;
      @(posedge clk); #1;
    end
    avs_read = 1'b0;
    if (!done) waits = 99;
  endtask

  initial begin
    vec_t        vecs[$];
    logic [7:0]  a1;
    logic        bz1;
    logic [31:0] d1, dend, rd;
    int          waits;
    string       tag;

    vecs.push_back('{OP_CW,  8'h12, 32'hDEAD_BEEF, 4'hF, 32'h0});
    vecs.push_back('{OP_CR,  8'h12, 32'h0,         4'h0, 32'hDEAD_BEEF});
    vecs.push_back('{OP_JLR, 8'h12, 32'h0,         4'h0, 32'hDEAD_BEEF});
    vecs.push_back('{OP_JL,  8'hFE, 32'h0,         4'h0, 32'h0});
    vecs.push_back('{OP_JW,  8'hFF, 32'h0000_0001, 4'h0, 32'h0});
    vecs.push_back('{OP_JW,  8'h00, 32'h0000_0002, 4'h0, 32'h0});
    vecs.push_back('{OP_JW,  8'h01, 32'h0000_0003, 4'h0, 32'h0});
    vecs.push_back('{OP_CR,  8'hFE, 32'h0,         4'h0, 32'h0000_0001});
    vecs.push_back('{OP_CR,  8'hFF, 32'h0,         4'h0, 32'h0000_0002});
    vecs.push_back('{OP_CR,  8'h00, 32'h0,         4'h0, 32'h0000_0003});
    vecs.push_back('{OP_CW,  8'h10, 32'hA0A0_A0A0, 4'hF, 32'h0});
    vecs.push_back('{OP_CW,  8'h11, 32'hB1B1_B1B1, 4'hF, 32'h0});
    vecs.push_back('{OP_JL,  8'h10, 32'h0,         4'h0, 32'h0});
    vecs.push_back('{OP_JN,  8'h11, 32'h0,         4'h0, 32'hA0A0_A0A0});
    vecs.push_back('{OP_JN,  8'h12, 32'h0,         4'h0, 32'hB1B1_B1B1});
    vecs.push_back('{OP_CW,  8'h20, 32'h1122_3344, 4'hF, 32'h0});
    vecs.push_back('{OP_CW,  8'h20, 32'hAABB_CCDD, 4'h5, 32'h0});
    vecs.push_back('{OP_CR,  8'h20, 32'h0,         4'h0, 32'h11BB_33DD});
    vecs.push_back('{OP_CW,  8'h21, 32'h0000_0000, 4'hF, 32'h0});
    vecs.push_back('{OP_CW,  8'h21, 32'hFFFF_FFFF, 4'hA, 32'h0});
    vecs.push_back('{OP_CR,  8'h21, 32'h0,         4'h0, 32'hFF00_FF00});
    vecs.push_back('{OP_JL,  8'hC0, 32'h0,         4'h0, 32'h0});
    vecs.push_back('{OP_JW,  8'hC1, 32'h1234_5678, 4'h0, 32'h0});
    vecs.push_back('{OP_CW,  8'hC0, 32'h0000_0055, 4'hF, 32'h0});
    vecs.push_back('{OP_CR,  8'hC0, 32'h0,         4'h0, PROT_EXP});
    vecs.push_back('{OP_JL,  8'hC0, 32'h0,         4'h0, 32'h0});
    vecs.push_back('{OP_JW,  8'hC1, 32'h9ABC_DEF0, 4'h0, 32'h0});
    vecs.push_back('{OP_CR,  8'hC0, 32'h0,         4'h0, 32'h9ABC_DEF0});
    vecs.push_back('{OP_CW,  8'hBF, 32'h0000_0077, 4'hF, 32'h0});
    vecs.push_back('{OP_CR,  8'hBF, 32'h0,         4'h0, 32'h0000_0077});
    vecs.push_back('{OP_JL,  8'h50, 32'h0,         4'h0, 32'h0});
    vecs.push_back('{OP_JBA, 8'h51, 32'h00FF_C000, 4'h0, 32'h0});
    vecs.push_back('{OP_CR,  8'h50, 32'h0,         4'h0, 32'h00FF_C000});

    // Reset, with a CPU read held to observe waitrequest.
    reset = 1'b1;
    jdo = '0;
    take_action_ocimem_a = 1'b0; take_no_action_ocimem_a = 1'b0; take_action_ocimem_b = 1'b0;
    avs_address = 8'h00; avs_read = 1'b1; avs_write = 1'b0;
    avs_writedata = '0; avs_byteenable = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset waitrequest", 32'(avs_waitrequest), 32'h1);
    check("reset MonDReg", MonDReg, 32'h0);
    check("reset MonAReg", 32'(MonAReg), 32'h0);
    check("reset jtag_busy", 32'(jtag_busy), 32'h0);
    check("reset avs_readdata", avs_readdata, 32'h0);
    @(posedge clk); #1;
    avs_read = 1'b0;
    reset = 1'b0;
    idle(2);

    for (int i = 0; i < vecs.size(); i++) begin
      tag = $sformatf("vec%0d", i);
      case (vecs[i].op)
        OP_CW: begin
          cpu_write(vecs[i].addr, vecs[i].data, vecs[i].be, waits);
          check({tag, " cpu_wr waits"}, 32'(waits), 32'd0);
        end
        OP_CR: begin
          cpu_read(vecs[i].addr, rd, waits);
          check({tag, " cpu_rd waits"}, 32'(waits), 32'd1);
          check({tag, " cpu_rd data"}, rd, vecs[i].exp);
        end
        OP_JL: begin
          jtag_op(1'b1, 1'b0, 1'b0, mk_jdo_a(1'b0, vecs[i].addr), a1, bz1, d1, dend);
          check({tag, " load MonAReg"}, 32'(a1), 32'(vecs[i].addr));
          check({tag, " load busy"}, 32'(bz1), 32'h0);
        end
        OP_JLR: begin
          jtag_op(1'b1, 1'b0, 1'b0, mk_jdo_a(1'b1, vecs[i].addr), a1, bz1, d1, dend);
          check({tag, " ldrd MonAReg"}, 32'(a1), 32'(vecs[i].addr));
          check({tag, " ldrd busy"}, 32'(bz1), 32'h1);
          check({tag, " ldrd MonDReg"}, dend, vecs[i].exp);
        end
        OP_JW: begin
          jtag_op(1'b0, 1'b0, 1'b1, mk_jdo_b(vecs[i].data), a1, bz1, d1, dend);
          check({tag, " jwr MonAReg"}, 32'(a1), 32'(vecs[i].addr));
          check({tag, " jwr busy"}, 32'(bz1), 32'h1);
          check({tag, " jwr MonDReg"}, d1, vecs[i].data);
        end
        OP_JN: begin
          jtag_op(1'b0, 1'b1, 1'b0, '0, a1, bz1, d1, dend);
          check({tag, " jrd MonAReg"}, 32'(a1), 32'(vecs[i].addr));
          check({tag, " jrd MonDReg"}, dend, vecs[i].exp);
        end
        OP_JBA: begin
          jtag_op(1'b1, 1'b0, 1'b1, mk_jdo_b(vecs[i].data) | mk_jdo_a(1'b1, 8'h00),
                  a1, bz1, d1, dend);
          check({tag, " prio MonAReg"}, 32'(a1), 32'(vecs[i].addr));
          check({tag, " prio MonDReg"}, dend, vecs[i].data);
        end
        default: ;
      endcase
    end

    // JTAG read timing: busy in T+1/T+2, data from T+3.
    idle(2);
    pulse(1'b1, 1'b0, 1'b0, mk_jdo_a(1'b1, 8'h12));
    @(negedge clk);
    check("ldrd T+1 MonAReg", 32'(MonAReg), 32'h12);
    check("ldrd T+1 busy", 32'(jtag_busy), 32'h1);
    @(posedge clk); #1; @(negedge clk);
    check("ldrd T+2 busy", 32'(jtag_busy), 32'h1);
    @(posedge clk); #1; @(negedge clk);
    check("ldrd T+3 busy", 32'(jtag_busy), 32'h0);
    check("ldrd T+3 MonDReg", MonDReg, 32'hDEAD_BEEF);
    @(posedge clk); #1;

    // Contention: CPU read asserted in the cycle after a no_action strobe.
    cpu_write(8'h05, 32'h0505_A5A5, 4'hF, waits);
    cpu_write(8'h30, 32'hCAFE_F00D, 4'hF, waits);
    jtag_op(1'b1, 1'b0, 1'b0, mk_jdo_a(1'b0, 8'h30), a1, bz1, d1, dend);
    pulse(1'b0, 1'b1, 1'b0, '0);
    cpu_read(8'h05, rd, waits);
    check("contend rd waits", 32'(waits), 32'd3);
    check("contend rd data", rd, 32'h0505_A5A5);
    check("contend MonDReg", MonDReg, 32'hCAFE_F00D);
    check("contend MonAReg", 32'(MonAReg), 32'h31);
    idle(8);
    pulse(1'b0, 1'b0, 1'b1, mk_jdo_b(32'h0BAD_F00D));
    cpu_write(8'h40, 32'h4040_4040, 4'hF, waits);
    check("contend wr waits", 32'(waits), 32'd1);
    idle(8);
    cpu_read(8'h31, rd, waits);
    check("contend jwr data", rd, 32'h0BAD_F00D);
    cpu_read(8'h40, rd, waits);
    check("contend cwr data", rd, 32'h4040_4040);

    // Reset in T+1 of a JTAG read.
    jtag_op(1'b1, 1'b0, 1'b0, mk_jdo_a(1'b1, 8'h12), a1, bz1, d1, dend);
    check("pre-reset MonDReg", dend, 32'hDEAD_BEEF);
    idle(2);
    pulse(1'b1, 1'b0, 1'b0, mk_jdo_a(1'b1, 8'h21));
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst-mid MonDReg", MonDReg, 32'h0);
    check("rst-mid MonAReg", 32'(MonAReg), 32'h0);
    check("rst-mid busy", 32'(jtag_busy), 32'h0);
    @(posedge clk); #1;
    idle(3);
    @(negedge clk);
    check("rst-mid MonDReg later", MonDReg, 32'h0);
    @(posedge clk); #1;
    cpu_read(8'h12, rd, waits);
    check("rst-mid ram kept", rd, 32'hDEAD_BEEF);
    idle(4);
    jtag_op(1'b1, 1'b0, 1'b0, mk_jdo_a(1'b1, 8'h21), a1, bz1, d1, dend);
    check("post-reset jtag rd", dend, 32'hFF00_FF00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
